// File: rtl/rooth_bus_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the rooth system-bus arbiter.
package rooth_bus_arbiter_pkg;

  localparam logic [1:0] ARB_M_CORE = 2'd0;
  localparam logic [1:0] ARB_M_JTAG = 2'd1;
  localparam logic [1:0] ARB_M_UART = 2'd2;
  localparam logic [1:0] ARB_M_NONE = 2'd3;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  function automatic logic [2:0] id_onehot(input logic [1:0] id);
    case (id)
      ARB_M_CORE: return 3'b001;
      ARB_M_JTAG: return 3'b010;
      ARB_M_UART: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rooth_bus_arbiter_if.sv
// Bundle of master-side request/response and slave-side bus signals around the arbiter.
interface rooth_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [2:0]          m_req;
  logic [2:0]          m_we;
  logic [3*ADDR_W-1:0] m_addr;
  logic [3*DATA_W-1:0] m_wdata;
  logic [2:0]          m_ack;
  logic [2:0]          m_err;
  logic [DATA_W-1:0]   m_rdata;
  logic                s_valid;
  logic                s_we;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic                s_ready;
  logic [DATA_W-1:0]   s_rdata;
  logic                hold_flag;
  logic [1:0]          grant_id;

  // The arbiter drives the bus as master; the SoC side (masters plus decoder) is the slave view.
  modport master (
    input  m_req, m_we, m_addr, m_wdata, s_ready, s_rdata,
    output m_ack, m_err, m_rdata, s_valid, s_we, s_addr, s_wdata, hold_flag, grant_id
  );

  modport slave (
    output m_req, m_we, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ack, m_err, m_rdata, s_valid, s_we, s_addr, s_wdata, hold_flag, grant_id
  );

endinterface

// File: rtl/rooth_arb_pick.sv
// Combinational winner selection: m1 > m2 > m0, unless the core is owed a turn.
module rooth_arb_pick
  import rooth_bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic       core_turn,
  output logic [1:0] id
);

  always_comb begin
    id = ARB_M_NONE;
    if (core_turn && req[0]) begin
      id = ARB_M_CORE;
    end else if (req[1]) begin
      id = ARB_M_JTAG;
    end else if (req[2]) begin
      id = ARB_M_UART;
    end else if (req[0]) begin
      id = ARB_M_CORE;
    end
  end

endmodule

// File: rtl/rooth_bus_arbiter.sv
// Three-master system-bus arbiter: registers the winning request, waits for the slave
// with a timeout, returns a one-cycle ack, and stalls the core while a debug master owns the bus.
module rooth_bus_arbiter
  import rooth_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  rooth_bus_arbiter_if.master bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state;
  arb_state_e        next_state;
  logic [1:0]        pick_id;
  logic [1:0]        grant_q;
  logic              core_turn;
  logic [7:0]        wait_cnt;
  logic              err_flag;
  logic              s_valid_q;
  logic              s_we_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic [DATA_W-1:0] m_rdata_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              start;
  logic              done_ok;
  logic              done_to;

  rooth_arb_pick u_pick (
    .req       (bus.m_req),
    .core_turn (core_turn),
    .id        (pick_id)
  );

  assign start   = (state == ARB_IDLE) && (bus.m_req != 3'b000);
  assign done_ok = (state == ARB_BUSY) && bus.s_ready;
  assign done_to = (state == ARB_BUSY) && !bus.s_ready && (wait_cnt == TIMEOUT_LAST);

  always_comb begin
    sel_we    = bus.m_we[0];
    sel_addr  = bus.m_addr[0 +: ADDR_W];
    sel_wdata = bus.m_wdata[0 +: DATA_W];
    case (pick_id)
      ARB_M_JTAG: begin
        sel_we    = bus.m_we[1];
        sel_addr  = bus.m_addr[ADDR_W +: ADDR_W];
        sel_wdata = bus.m_wdata[DATA_W +: DATA_W];
      end
      ARB_M_UART: begin
        sel_we    = bus.m_we[2];
        sel_addr  = bus.m_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = bus.m_wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: if (start) next_state = ARB_BUSY;
      ARB_BUSY: if (done_ok || done_to) next_state = ARB_RESP;
      ARB_RESP: next_state = ARB_IDLE;
      default:  next_state = ARB_IDLE;
    endcase
  end

  // Request latch, slave wait counter, response capture and the core fairness token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= ARB_M_NONE;
      core_turn <= 1'b0;
      wait_cnt  <= 8'd0;
      err_flag  <= 1'b0;
      s_valid_q <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (start) begin
            grant_q   <= pick_id;
            s_valid_q <= 1'b1;
            s_we_q    <= sel_we;
            s_addr_q  <= sel_addr;
            s_wdata_q <= sel_wdata;
            if (pick_id == ARB_M_CORE) core_turn <= 1'b0;
          end
        end
        ARB_BUSY: begin
          if (bus.s_ready) begin
            m_rdata_q <= bus.s_rdata;
            s_valid_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (done_to) begin
              s_valid_q <= 1'b0;
              err_flag  <= 1'b1;
              m_rdata_q <= '0;
            end
          end
        end
        ARB_RESP: begin
          wait_cnt <= 8'd0;
          err_flag <= 1'b0;
          grant_q  <= ARB_M_NONE;
          if (grant_q != ARB_M_CORE && bus.m_req[0]) core_turn <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.m_ack = 3'b000;
    bus.m_err = 3'b000;
    if (state == ARB_RESP) begin
      bus.m_ack = id_onehot(grant_q);
      if (err_flag) bus.m_err = id_onehot(grant_q);
    end
    bus.hold_flag = (state != ARB_IDLE) ? (grant_q != ARB_M_CORE)
                                        : (bus.m_req[1] | bus.m_req[2]);
  end

  assign bus.s_valid  = s_valid_q;
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_rooth_bus_arbiter.sv
// Directed bench for rooth_bus_arbiter: a table of single transactions plus
// hand-written sequences for fairness, timeout, late ready, back-to-back and mid-transfer reset.
module tb_rooth_bus_arbiter;
  import rooth_bus_arbiter_pkg::*;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    int          wait_cyc;
    logic [31:0] rdata;
    logic [1:0]  exp_id;
    logic        exp_hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] addr_tab [3];
  logic [31:0] wdata_tab [3];
  vec_t        vecs [12];

  logic [1:0]  obs_gid;
  logic [1:0]  obs_gid_after;
  logic        obs_valid;
  logic        obs_we;
  logic        obs_hold;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_rdata;
  logic [2:0]  obs_ack;
  logic [2:0]  obs_err;

  rooth_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rooth_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from the IDLE sample cycle through RESP and back to IDLE.
  task automatic apply_stimulus(input vec_t v);
    bus.m_req   = v.req;
    bus.m_we    = v.we;
    bus.s_ready = 1'b0;
    tick();
    obs_gid   = bus.grant_id;
    obs_valid = bus.s_valid;
    obs_we    = bus.s_we;
    obs_addr  = bus.s_addr;
    obs_wdata = bus.s_wdata;
    obs_hold  = bus.hold_flag;
    for (int w = 0; w < v.wait_cyc; w++) tick();
    bus.s_ready = 1'b1;
    bus.s_rdata = v.rdata;
    tick();
    bus.s_ready = 1'b0;
    obs_ack   = bus.m_ack;
    obs_err   = bus.m_err;
    obs_rdata = bus.m_rdata;
    tick();
    bus.m_req     = 3'b000;
    bus.m_we      = 3'b000;
    obs_gid_after = bus.grant_id;
  endtask

  task automatic check_vector(input int i, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", i);
    check_output({tag, "_grant"}, 32'(obs_gid), 32'(v.exp_id));
    check_output({tag, "_s_valid"}, 32'(obs_valid), 32'd1);
    check_output({tag, "_s_addr"}, obs_addr, addr_tab[v.exp_id]);
    check_output({tag, "_s_wdata"}, obs_wdata, wdata_tab[v.exp_id]);
    check_output({tag, "_s_we"}, 32'(obs_we), 32'(v.we[v.exp_id]));
    check_output({tag, "_hold"}, 32'(obs_hold), 32'(v.exp_hold));
    check_output({tag, "_ack"}, 32'(obs_ack), 32'(3'b001 << v.exp_id));
    check_output({tag, "_err"}, 32'(obs_err), 32'd0);
    check_output({tag, "_rdata"}, obs_rdata, v.rdata);
    check_output({tag, "_grant_after"}, 32'(obs_gid_after), 32'd3);
  endtask

  initial begin
    int   n;
    int   m0_acks;
    int   valid_cycles;
    int   id;
    logic [2:0] drop;
    int   order [4];
    logic hold_at [4];
    int   exp_order [4];
    logic exp_hold_at [4];
    vec_t fresh;

    addr_tab[0]  = 32'h1000_0004;
    addr_tab[1]  = 32'h3000_0010;
    addr_tab[2]  = 32'h2000_0000;
    wdata_tab[0] = 32'hC0DE_0000;
    wdata_tab[1] = 32'h0BAD_F00D;
    wdata_tab[2] = 32'h0000_0055;

    // Vectors are ordered so the core_turn token carries between them.
    vecs[0]  = '{3'b001, 3'b000, 1, 32'hDEAD_BEEF, 2'd0, 1'b0};
    vecs[1]  = '{3'b010, 3'b010, 2, 32'h1111_2222, 2'd1, 1'b1};
    vecs[2]  = '{3'b100, 3'b000, 0, 32'h3333_4444, 2'd2, 1'b1};
    vecs[3]  = '{3'b110, 3'b100, 0, 32'h5555_6666, 2'd1, 1'b1};
    vecs[4]  = '{3'b101, 3'b100, 1, 32'h7777_8888, 2'd2, 1'b1};
    vecs[5]  = '{3'b011, 3'b001, 0, 32'h9999_AAAA, 2'd0, 1'b0};
    vecs[6]  = '{3'b011, 3'b000, 3, 32'hBBBB_CCCC, 2'd1, 1'b1};
    vecs[7]  = '{3'b111, 3'b000, 0, 32'hDDDD_EEEE, 2'd0, 1'b0};
    vecs[8]  = '{3'b111, 3'b111, 0, 32'h0102_0304, 2'd1, 1'b1};
    vecs[9]  = '{3'b100, 3'b000, 0, 32'h0506_0708, 2'd2, 1'b1};
    vecs[10] = '{3'b110, 3'b000, 0, 32'h090A_0B0C, 2'd1, 1'b1};
    vecs[11] = '{3'b001, 3'b000, 0, 32'h0D0E_0F10, 2'd0, 1'b0};

    rst_n       = 1'b0;
    bus.m_req   = 3'b000;
    bus.m_we    = 3'b000;
    bus.m_addr  = {addr_tab[2], addr_tab[1], addr_tab[0]};
    bus.m_wdata = {wdata_tab[2], wdata_tab[1], wdata_tab[0]};
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;

    repeat (3) tick();
    check_output("rst_s_valid", 32'(bus.s_valid), 32'd0);
    check_output("rst_grant", 32'(bus.grant_id), 32'd3);
    check_output("rst_ack", 32'(bus.m_ack), 32'd0);
    check_output("rst_rdata", bus.m_rdata, 32'd0);
    check_output("rst_s_addr", bus.s_addr, 32'd0);
    check_output("rst_hold", 32'(bus.hold_flag), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end

    // All three request together and hold until acked; m0 issues two transactions.
    exp_order   = '{1, 0, 2, 0};
    exp_hold_at = '{1'b1, 1'b0, 1'b1, 1'b0};
    order       = '{3, 3, 3, 3};
    hold_at     = '{1'bx, 1'bx, 1'bx, 1'bx};
    bus.m_req   = 3'b111;
    bus.m_we    = 3'b000;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    n = 0;
    m0_acks = 0;
    drop = 3'b000;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      tick();
      bus.m_req = bus.m_req & ~drop;
      drop = 3'b000;
      if (bus.m_ack != 3'b000) begin
        case (bus.m_ack)
          3'b001:  id = 0;
          3'b010:  id = 1;
          3'b100:  id = 2;
          default: id = 3;
        endcase
        order[n]   = id;
        hold_at[n] = bus.hold_flag;
        n++;
        if (id == 0) begin
          m0_acks++;
          if (m0_acks >= 2) drop = 3'b001;
        end else begin
          drop = bus.m_ack;
        end
      end
    end
    tick();
    bus.m_req   = 3'b000;
    bus.s_ready = 1'b0;
    check_output("rr_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      check_output($sformatf("rr_hold%0d", k), 32'(hold_at[k]), 32'(exp_hold_at[k]));
    end

    // m2 write that the slave never answers.
    bus.m_req = 3'b100;
    bus.m_we  = 3'b100;
    tick();
    valid_cycles = 0;
    for (int c = 0; c < 400 && bus.s_valid; c++) begin
      valid_cycles++;
      tick();
    end
    check_output("to_valid_cycles", 32'(valid_cycles), 32'd255);
    check_output("to_ack", 32'(bus.m_ack), 32'(3'b100));
    check_output("to_err", 32'(bus.m_err), 32'(3'b100));
    check_output("to_rdata", bus.m_rdata, 32'd0);
    tick();
    bus.m_req = 3'b000;
    bus.m_we  = 3'b000;
    check_output("to_grant_after", 32'(bus.grant_id), 32'd3);

    // Ready arrives in the last BUSY cycle before the timeout would fire.
    bus.m_req = 3'b001;
    tick();
    repeat (254) tick();
    check_output("late_valid", 32'(bus.s_valid), 32'd1);
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'hA5A5_0FF0;
    tick();
    bus.s_ready = 1'b0;
    check_output("late_ack", 32'(bus.m_ack), 32'(3'b001));
    check_output("late_err", 32'(bus.m_err), 32'd0);
    check_output("late_rdata", bus.m_rdata, 32'hA5A5_0FF0);
    tick();
    bus.m_req = 3'b000;

    // Core keeps requesting with a zero-wait slave.
    bus.m_req   = 3'b001;
    bus.s_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.m_addr[31:0] = 32'h4000_0000 + 32'(k * 16);
      bus.s_rdata      = 32'hB000_0000 + 32'(k);
      tick();
      check_output($sformatf("b2b_s_addr%0d", k), bus.s_addr, 32'h4000_0000 + 32'(k * 16));
      check_output($sformatf("b2b_busy_ack%0d", k), 32'(bus.m_ack), 32'd0);
      tick();
      check_output($sformatf("b2b_ack%0d", k), 32'(bus.m_ack), 32'(3'b001));
      check_output($sformatf("b2b_rdata%0d", k), bus.m_rdata, 32'hB000_0000 + 32'(k));
      tick();
    end
    bus.m_req        = 3'b000;
    bus.s_ready      = 1'b0;
    bus.m_addr[31:0] = addr_tab[0];
    tick();

    // Reset two cycles into BUSY.
    bus.m_req = 3'b001;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_s_valid", 32'(bus.s_valid), 32'd0);
    check_output("mid_rst_grant", 32'(bus.grant_id), 32'd3);
    check_output("mid_rst_ack", 32'(bus.m_ack), 32'd0);
    bus.m_req = 3'b000;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_output($sformatf("mid_rst_hold_ack%0d", k), 32'(bus.m_ack), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    fresh = '{3'b001, 3'b000, 0, 32'hFEED_F00D, 2'd0, 1'b0};
    apply_stimulus(fresh);
    check_vector(99, fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
